ram_req_master: RTL and testbench

- Initiator for the team's strobe-based read/write-separate RAM interface: addr, datain, level-sensitive read with tri-stated dataout, and rising-edge-triggered write.
- Converts clocked valid/ready requests, single-beat or burst, into correctly sequenced RAM strobes with programmable setup/hold.
- Read data returns on a valid/ready response channel.
- Sits between any synchronous client (test sequencer, CPU stub) and the RAM.

---
 rtl/ram_if_pkg.sv | 9 +
 rtl/ram_strobe_timer.sv | 20 ++
 rtl/ram_req_master.sv | 103 ++++++++++
 tb/tb_ram_req_master.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_if_pkg.sv
// ram_if_pkg: shared FSM states, default widths and wrap helper for the strobe RAM interface
package ram_if_pkg;
    localparam int RAM_AW = 4;
    localparam int RAM_DW = 4;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_RSP} ram_state_e;
    function automatic logic [31:0] inc_wrap(input logic [31:0] value, input int width);
        return (value + 32'd1) & ((32'd1 << width) - 32'd1);
    endfunction
endpackage

// File: rtl/ram_strobe_timer.sv
// ram_strobe_timer: down-counter loaded with a phase length, expire while it sits at zero
module ram_strobe_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         expire
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk)
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= value;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;
    assign expire = cnt == '0;
endmodule

// File: rtl/ram_req_master.sv
// ram_req_master: turns valid/ready single or burst requests into timed RAM read/write strobes
module ram_req_master
    import ram_if_pkg::*;
#(
    parameter int AW    = RAM_AW,
    parameter int DW    = RAM_DW,
    parameter int SETUP = 1,
    parameter int HOLD  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_datain,
    output logic          ram_read,
    output logic          ram_write,
    input  logic [DW-1:0] ram_dataout
);
    localparam int TW = $clog2((SETUP > HOLD ? SETUP : HOLD) + 1);
    ram_state_e    state, state_n;
    logic          wr, wr_n, accept, last, step, expire, load;
    logic          ram_write_d, ram_read_d, rsp_valid_d, done_d, req_ready_d;
    logic [TW-1:0] tval;
    logic [AW-1:0] len, cnt;
    assign accept = req_valid & req_ready;
    assign last   = cnt == len;
    assign step   = (state == S_HOLD && expire) || (state == S_RSP && rsp_valid && rsp_ready);
    assign wr_n   = accept ? req_write : wr;
    ram_strobe_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (tval),
        .expire(expire)
    );
    always_ff @(posedge clk)
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:        state_n = accept ? S_SETUP : S_IDLE;
            S_SETUP:       state_n = expire ? S_STROBE : S_SETUP;
            S_STROBE:      state_n = wr ? S_HOLD : S_RSP;
            S_HOLD, S_RSP: state_n = step ? (last ? S_IDLE : S_SETUP) : state;
            default:       state_n = S_IDLE;
        endcase
    end
    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        load        = state_n != state && (state_n == S_SETUP || state_n == S_HOLD);
        tval        = state_n == S_SETUP ? TW'(SETUP - 1) : TW'(HOLD - 1);
        ram_write_d = state_n == S_STROBE && wr_n;
        ram_read_d  = (state_n == S_SETUP || state_n == S_STROBE) && !wr_n;
        rsp_valid_d = state_n == S_RSP;
        done_d      = step && last;
        req_ready_d = state_n == S_IDLE && !done_d;
    end
    always_ff @(posedge clk)
        if (!rst_n) begin
            wr         <= 1'b0;
            len        <= '0;
            cnt        <= '0;
            ram_addr   <= '0;
            ram_datain <= '0;
            rsp_rdata  <= '0;
            ram_write  <= 1'b0;
            ram_read   <= 1'b0;
            rsp_valid  <= 1'b0;
            done       <= 1'b0;
            req_ready  <= 1'b1;
        end else begin
            ram_write <= ram_write_d;
            ram_read  <= ram_read_d;
            rsp_valid <= rsp_valid_d;
            done      <= done_d;
            req_ready <= req_ready_d;
            if (accept) begin
                wr         <= req_write;
                len        <= req_len;
                cnt        <= '0;
                ram_addr   <= req_addr;
                ram_datain <= req_wdata;
            end else if (step && !last) begin
                cnt        <= cnt + 1'b1;
                ram_addr   <= AW'(inc_wrap(32'(ram_addr), AW));
                ram_datain <= DW'(inc_wrap(32'(ram_datain), DW));
            end
            if (state == S_STROBE && !wr)
                rsp_rdata <= ram_dataout;
        end
endmodule

// File: tb/tb_ram_req_master.sv
// tb_ram_req_master: directed and random requests against a RAM model and a spec-level expected memory
module tb_ram_req_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic       rst_n = 1'b0, req_valid = 1'b0, req_valid2 = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
    logic [3:0] req_addr = '0, req_len = '0, req_wdata = '0;
    logic       req_ready, rsp_valid, done, ram_read, ram_write;
    logic [3:0] rsp_rdata, ram_addr, ram_datain, ram_dataout;
    logic       req_ready2, rsp_valid2, done2, ram_read2, ram_write2;
    logic [3:0] rsp_rdata2, ram_addr2, ram_datain2;
    logic [3:0] mem [16];
    logic [3:0] exp_mem [16];
    int         vectors = 0, miscompares = 0, wr_edges = 0;
    logic       rst_edge = 1'b1, prev_write = 1'b0;
    logic [3:0] prev_addr = '0, prev_datain = '0;

    ram_req_master dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .done(done), .ram_addr(ram_addr),
        .ram_datain(ram_datain), .ram_read(ram_read), .ram_write(ram_write), .ram_dataout(ram_dataout)
    );
    ram_req_master #(.SETUP(3), .HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid2), .req_ready(req_ready2), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .rsp_valid(rsp_valid2),
        .rsp_ready(1'b1), .rsp_rdata(rsp_rdata2), .done(done2), .ram_addr(ram_addr2),
        .ram_datain(ram_datain2), .ram_read(ram_read2), .ram_write(ram_write2), .ram_dataout(4'h0)
    );

    // RAM model: garbage (inverted data) whenever read is not enabled
    assign ram_dataout = ram_read ? mem[ram_addr] : ~mem[ram_addr];
    always @(posedge ram_write) begin
        mem[ram_addr] = ram_datain;
        wr_edges++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) rst_edge <= !rst_n;
    always @(negedge clk) begin
        if (!rst_edge && (ram_write || prev_write))
            check("strobe_hold_stable", {ram_addr, ram_datain}, {prev_addr, prev_datain});
        prev_write  = ram_write;
        prev_addr   = ram_addr;
        prev_datain = ram_datain;
    end

    task automatic model_write(input logic [3:0] a, input logic [3:0] l, input logic [3:0] d);
        for (int k = 0; k <= int'(l); k++)
            exp_mem[(int'(a) + k) % 16] = 4'((int'(d) + k) % 16);
    endtask

    task automatic send(input logic w, input logic [3:0] a, input logic [3:0] l, input logic [3:0] d);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", n < 100, 1);
        req_valid = 1'b1; req_write = w; req_addr = a; req_len = l; req_wdata = d;
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_after_accept", req_ready, 0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_ready_back"}, req_ready, 1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] l, input logic [3:0] d);
        int e0 = wr_edges;
        send(1'b1, a, l, d);
        model_write(a, l, d);
        wait_done("wr");
        check("wr_edges", wr_edges - e0, int'(l) + 1);
        for (int k = 0; k <= int'(l); k++)
            check("wr_mem", mem[(int'(a) + k) % 16], exp_mem[(int'(a) + k) % 16]);
    endtask

    task automatic do_read(input logic [3:0] a, input logic [3:0] l, input int stall_beat, input int stall);
        send(1'b0, a, l, 4'h0);
        for (int k = 0; k <= int'(l); k++) begin
            int n = 0;
            logic [3:0] exp = exp_mem[(int'(a) + k) % 16];
            while (!rsp_valid && n < 200) begin
                @(negedge clk);
                n++;
            end
            check("rsp_valid_seen", rsp_valid, 1);
            check("rsp_read_low", ram_read, 0);
            check("rsp_rdata", rsp_rdata, exp);
            if (k == stall_beat)
                repeat (stall) begin
                    @(negedge clk);
                    check("stall_valid", rsp_valid, 1);
                    check("stall_rdata", rsp_rdata, exp);
                    check("stall_read_low", ram_read, 0);
                end
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
            check("rsp_drop", rsp_valid, 0);
            check("rd_done_at_last", done, k == int'(l));
        end
        @(negedge clk);
        check("rd_done_pulse", done, 0);
        check("rd_ready_back", req_ready, 1);
    endtask

    initial begin
        int e0, n;
        for (int i = 0; i < 16; i++) begin
            mem[i] = '0;
            exp_mem[i] = '0;
        end
        repeat (3) @(negedge clk);
        check("reset_outputs", {req_ready, rsp_valid, done, ram_read, ram_write, ram_addr, ram_datain, rsp_rdata}, 32'h10000);
        check("reset_outputs2", {req_ready2, rsp_valid2, done2, ram_read2, ram_write2, ram_addr2, ram_datain2, rsp_rdata2}, 32'h10000);
        rst_n = 1'b1;
        @(negedge clk);
        // single write with cycle-exact strobe placement
        send(1'b1, 4'd3, 4'd0, 4'hA);
        model_write(4'd3, 4'd0, 4'hA);
        for (int c = 1; c <= 3; c++) begin
            check("single_wr_cycle", {ram_write, ram_addr, ram_datain}, {c == 2, 4'd3, 4'hA});
            @(negedge clk);
        end
        check("single_done", done, 1);
        @(negedge clk);
        check("single_done_pulse", done, 0);
        check("single_ready_back", req_ready, 1);
        check("single_mem", mem[3], exp_mem[3]);
        do_write(4'd14, 4'd3, 4'hF);
        do_read(4'd14, 4'd3, 1, 3);
        // request held valid while busy must wait for the current one to finish
        e0 = wr_edges;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd2; req_len = 4'd0; req_wdata = 4'h9;
        @(negedge clk);
        req_addr = 4'd7; req_wdata = 4'h4;
        check("busy_ready_low", req_ready, 0);
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        model_write(4'd2, 4'd0, 4'h9);
        check("busy_done_seen", done, 1);
        check("busy_one_edge", wr_edges - e0, 1);
        check("busy_mem2", mem[2], exp_mem[2]);
        check("busy_mem7_untouched", mem[7], exp_mem[7]);
        @(negedge clk);
        check("busy_ready_after_done", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_second_accept", req_ready, 0);
        model_write(4'd7, 4'd0, 4'h4);
        wait_done("busy2");
        check("busy_two_edges", wr_edges - e0, 2);
        check("busy_mem7", mem[7], exp_mem[7]);
        // reset during the strobe of the second beat of a 4-beat write
        e0 = wr_edges;
        send(1'b1, 4'd8, 4'd3, 4'h5);
        n = 0;
        while (!(ram_write && wr_edges - e0 == 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_strobe_reached", n < 100, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_outputs", {req_ready, rsp_valid, done, ram_read, ram_write, ram_addr, ram_datain, rsp_rdata}, 32'h10000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model_write(4'd8, 4'd1, 4'h5);
        check("midreset_edges", wr_edges - e0, 2);
        for (int i = 8; i <= 11; i++)
            check("midreset_mem", mem[i], exp_mem[i]);
        do_read(4'd0, 4'd0, 0, 0);
        // longer setup/hold timing on the second instance
        req_write = 1'b1; req_addr = 4'd5; req_len = 4'd0; req_wdata = 4'h6; req_valid2 = 1'b1;
        @(negedge clk);
        req_valid2 = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check("u2_cycle", {ram_read2, ram_write2, ram_addr2, ram_datain2}, {1'b0, c == 4, 4'd5, 4'd6});
            @(negedge clk);
        end
        check("u2_done", done2, 1);
        @(negedge clk);
        check("u2_ready_back", req_ready2, 1);
        // random mix
        for (int i = 0; i < 16; i++) begin
            logic [3:0] a = 4'($urandom), l = 4'($urandom_range(0, 3)), d = 4'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_write(a, l, d);
            else
                do_read(a, l, $urandom_range(0, int'(l)), $urandom_range(0, 2));
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
